// File: rtl/d_mem_arbiter_pkg.sv
// rtl/d_mem_arbiter_pkg.sv - shared types and constants for the d_mem arbiter
package d_mem_arbiter_pkg;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_ADDR_WIDTH = 32;

  // First address outside d_mem; anything at or above it is rejected.
  localparam logic [31:0] DMEM_ADDR_LIMIT = 32'h0000_4000;

  // Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/d_mem_arbiter_if.sv
// rtl/d_mem_arbiter_if.sv - requester and d_mem pin bundle for the arbiter
interface d_mem_arbiter_if
  import d_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
);

  // Port 0: core load/store unit
  logic                  r0_req;
  logic                  r0_we;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic                  r0_ack;
  logic                  r0_err;
  logic [DATA_WIDTH-1:0] r0_rdata;

  // Port 1: loader/debug DMA
  logic                  r1_req;
  logic                  r1_we;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_ack;
  logic                  r1_err;
  logic [DATA_WIDTH-1:0] r1_rdata;

  // d_mem pins
  logic [ADDR_WIDTH-1:0] mem_adr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_WrEn;
  logic [DATA_WIDTH-1:0] mem_data_out;

  // Arbiter side
  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_ack, r0_err, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_ack, r1_err, r1_rdata,
    output mem_adr, mem_data_in, mem_WrEn,
    input  mem_data_out
  );

  // Requesters plus the memory itself
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_ack, r0_err, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_ack, r1_err, r1_rdata,
    input  mem_adr, mem_data_in, mem_WrEn,
    output mem_data_out
  );

endinterface

// File: rtl/d_mem_arbiter_rr_arb2.sv
// rtl/d_mem_arbiter_rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       any_o
);

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt_o    = 2'b00;
    gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
    gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
    any_o    = |req_i;
  end

endmodule

// File: rtl/d_mem_arbiter.sv
// rtl/d_mem_arbiter.sv - round-robin arbiter and access sequencer for d_mem
module d_mem_arbiter
  import d_mem_arbiter_pkg::*;
#(
  parameter int                    DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DMEM_ADDR_LIMIT)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  d_mem_arbiter_if.slave  bus
);

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  any_req;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  cmd_oor;

  arb_state_e                 state_q;
  logic                       rr_last_q;
  logic                       win_q;
  logic                       we_q;
  logic                       oor_q;
  logic [ADDR_WIDTH-1:0]      mem_adr_q;
  logic [DATA_WIDTH-1:0]      mem_data_in_q;
  logic                       mem_wren_q;
  logic [1:0]                 ack_q;
  logic [1:0]                 err_q;
  logic [1:0][DATA_WIDTH-1:0] rdata_q;

  assign req = {bus.r1_req, bus.r0_req};

  rr_arb2 u_rr_arb2 (
    .req_i  (req),
    .last_i (rr_last_q),
    .gnt_o  (gnt),
    .any_o  (any_req)
  );

  // Steer the winning requester's command toward the command registers.
  always_comb begin
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    if (gnt[0]) begin
      cmd_we    = bus.r0_we;
      cmd_addr  = bus.r0_addr;
      cmd_wdata = bus.r0_wdata;
    end else if (gnt[1]) begin
      cmd_we    = bus.r1_we;
      cmd_addr  = bus.r1_addr;
      cmd_wdata = bus.r1_wdata;
    end
    cmd_oor = (cmd_addr >= ADDR_LIMIT);
  end

  // IDLE -> ACCESS -> DONE sequencer; every output is registered here.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      rr_last_q     <= 1'b1;
      win_q         <= 1'b0;
      we_q          <= 1'b0;
      oor_q         <= 1'b0;
      mem_adr_q     <= '0;
      mem_data_in_q <= '0;
      mem_wren_q    <= 1'b0;
      ack_q         <= 2'b00;
      err_q         <= 2'b00;
      rdata_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 2'b00;
          err_q <= 2'b00;
          if (any_req) begin
            win_q         <= gnt[1];
            rr_last_q     <= gnt[1];
            we_q          <= cmd_we;
            oor_q         <= cmd_oor;
            mem_adr_q     <= cmd_addr;
            mem_data_in_q <= cmd_wdata;
            mem_wren_q    <= cmd_we & ~cmd_oor;
            state_q       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // d_mem acted on the falling edge inside this cycle.
          mem_wren_q   <= 1'b0;
          ack_q[win_q] <= 1'b1;
          err_q[win_q] <= oor_q;
          if (!we_q) begin
            rdata_q[win_q] <= oor_q ? '0 : bus.mem_data_out;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          // Requests are deliberately ignored while the ack is visible.
          ack_q   <= 2'b00;
          err_q   <= 2'b00;
          state_q <= ST_IDLE;
        end
        default: begin
          mem_wren_q <= 1'b0;
          ack_q      <= 2'b00;
          err_q      <= 2'b00;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_adr     = mem_adr_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.mem_WrEn    = mem_wren_q;
  assign bus.r0_ack      = ack_q[0];
  assign bus.r0_err      = err_q[0];
  assign bus.r0_rdata    = rdata_q[0];
  assign bus.r1_ack      = ack_q[1];
  assign bus.r1_err      = err_q[1];
  assign bus.r1_rdata    = rdata_q[1];

endmodule

// File: tb/tb_d_mem_arbiter.sv
// tb/tb_d_mem_arbiter.sv - directed self-checking bench for d_mem_arbiter
module tb_d_mem_arbiter;
  import d_mem_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  d_mem_arbiter_if bus ();

  d_mem_arbiter dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d_mem behavioural model: acts on the falling edge
  logic [31:0] mem [0:4095];
  always @(negedge clk) begin
    if (bus.mem_WrEn) mem[bus.mem_adr[13:2]] <= bus.mem_data_in;
    bus.mem_data_out <= mem[bus.mem_adr[13:2]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit p, input logic rq, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 1'b0) begin
      bus.r0_req = rq; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_req = rq; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  // One complete access: grant edge, ACCESS cycle, DONE cycle, back to IDLE.
  task automatic do_access(input string tag, input bit p, input logic we,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic exp_wren, input logic exp_err,
                           input bit chk_rd, input logic [31:0] exp_rd);
    drive(p, 1'b1, we, a, d);
    tick;
    chk({tag, ".access_wren"}, {31'd0, bus.mem_WrEn}, {31'd0, exp_wren});
    chk({tag, ".access_adr"}, bus.mem_adr, a);
    chk({tag, ".access_acks"}, {30'd0, bus.r1_ack, bus.r0_ack}, 32'd0);
    tick;
    chk({tag, ".done_acks"}, {30'd0, bus.r1_ack, bus.r0_ack}, p ? 32'd2 : 32'd1);
    chk({tag, ".done_err"}, {31'd0, p ? bus.r1_err : bus.r0_err}, {31'd0, exp_err});
    chk({tag, ".done_wren"}, {31'd0, bus.mem_WrEn}, 32'd0);
    if (chk_rd) chk({tag, ".rdata"}, p ? bus.r1_rdata : bus.r0_rdata, exp_rd);
    drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    chk({tag, ".idle_acks"}, {30'd0, bus.r1_ack, bus.r0_ack}, 32'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  logic [31:0] held_adr;

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    bus.mem_data_out = 32'd0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    do_reset;

    // Reset state
    chk("rst.wren", {31'd0, bus.mem_WrEn}, 32'd0);
    chk("rst.acks", {30'd0, bus.r1_ack, bus.r0_ack}, 32'd0);
    chk("rst.errs", {30'd0, bus.r1_err, bus.r0_err}, 32'd0);
    chk("rst.adr", bus.mem_adr, 32'd0);
    chk("rst.din", bus.mem_data_in, 32'd0);
    chk("rst.r0_rdata", bus.r0_rdata, 32'd0);
    chk("rst.r1_rdata", bus.r1_rdata, 32'd0);

    // 1: r0 write then read back
    do_access("t1.wr", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("t1.mem", mem[4], 32'hDEADBEEF);
    do_access("t1.rd", 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);

    // 2: both ports requesting continuously after reset -> 0,1,0,1
    do_reset;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h14, 32'd0);
    for (int g = 0; g < 4; g++) begin
      tick;
      chk("t2.grant_adr", bus.mem_adr, (g % 2 == 0) ? 32'h10 : 32'h14);
      tick;
      chk("t2.grant_ack", {30'd0, bus.r1_ack, bus.r0_ack}, (g % 2 == 0) ? 32'd1 : 32'd2);
      tick;
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("t2.r0_rdata", bus.r0_rdata, 32'hDEADBEEF);

    // 3: out-of-range handling on port 1
    do_access("t3.wr_oor", 1'b1, 1'b1, 32'h4000, 32'hAAAA5555, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("t3.mem0", mem[0], 32'd0);
    do_access("t3.wr_3ffc", 1'b1, 1'b1, 32'h3FFC, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 32'd0);
    do_access("t3.rd_3ffc", 1'b1, 1'b0, 32'h3FFC, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    do_access("t3.rd_oor", 1'b1, 1'b0, 32'h4004, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0);

    // 4: r1 raises req during r0's DONE cycle
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    tick;
    tick;
    chk("t4.r0_ack", {31'd0, bus.r0_ack}, 32'd1);
    chk("t4.r0_rdata", bus.r0_rdata, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h30, 32'h00000055);
    tick;
    chk("t4.done_ignored_wren", {31'd0, bus.mem_WrEn}, 32'd0);
    chk("t4.done_ignored_adr", bus.mem_adr, 32'h10);
    tick;
    chk("t4.r1_wren", {31'd0, bus.mem_WrEn}, 32'd1);
    chk("t4.r1_adr", bus.mem_adr, 32'h30);
    tick;
    chk("t4.r1_ack", {30'd0, bus.r1_ack, bus.r0_ack}, 32'd2);
    chk("t4.r0_rdata_hold", bus.r0_rdata, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    chk("t4.mem30", mem[12], 32'h00000055);

    // 5: reset lands at the end of r1's write ACCESS cycle
    drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678);
    tick;
    chk("t5.access_wren", {31'd0, bus.mem_WrEn}, 32'd1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    chk("t5.no_ack", {30'd0, bus.r1_ack, bus.r0_ack}, 32'd0);
    chk("t5.wren_cleared", {31'd0, bus.mem_WrEn}, 32'd0);
    reset = 1'b0;
    tick;
    chk("t5.no_ack_after", {30'd0, bus.r1_ack, bus.r0_ack}, 32'd0);
    do_access("t5.rd", 1'b0, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 1'b1, 32'h12345678);

    // 6: ten idle cycles
    held_adr = bus.mem_adr;
    chk("t6.held_adr_start", held_adr, 32'h20);
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("t6.wren", {31'd0, bus.mem_WrEn}, 32'd0);
      chk("t6.acks", {30'd0, bus.r1_ack, bus.r0_ack}, 32'd0);
      chk("t6.adr", bus.mem_adr, 32'h20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
